// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmit path.
//   ps2_state_e : transmitter FSM states
//   PS2_CMD_*   : command bytes sent to the keyboard
//   PS2_RSP_ACK : keyboard acknowledge byte (seen by the receiver side)
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    DATA      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

  // Outbound frame after the start bit: {stop, parity, data[7:0]}
  localparam int unsigned FRAME_W = 10;

  // Odd parity: the parity bit makes the total count of ones odd
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 pin plus a falling-edge flag.
//   clock, resetn : system clock, async active-low reset (flops preset to 1)
//   pin           : raw asynchronous pin level
//   level         : synchronized level
//   fall          : one-cycle pulse, coincident with level going 1 -> 0
module ps2_line_sync (
  input  logic clock,
  input  logic resetn,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic meta;

  // fall compares the outgoing level with the incoming one, so it is
  // registered and lines up with the cycle where level drops
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta  <= 1'b1;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      meta  <= pin;
      level <= meta;
      fall  <= level & ~meta;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then shifts
// one command byte out on device-generated clock edges and checks line ACK.
//   clock, resetn          : system clock, async active-low reset
//   tx_valid/tx_data       : command byte offer; accepted when tx_ready
//   tx_ready               : high only when idle
//   tx_busy                : high whenever a frame is in progress
//   tx_done / tx_error     : one-cycle completion pulses (ACK / NACK or timeout)
//   ps2_clk_in, ps2_dat_in : raw pin levels
//   ps2_clk_oe, ps2_dat_oe : 1 pulls the open-drain line low
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned INH_W  = $clog2(INHIBIT_CYCLES);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned EDGE_W = 4;

  ps2_state_e          state_q, state_d;
  logic [INH_W-1:0]    inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic                clk_oe_d, dat_oe_d;
  logic                ready_d, busy_d, done_d, error_d;

  logic clk_level, clk_fall;
  logic dat_level, dat_fall_unused;

  ps2_line_sync u_clk_sync (
    .clock  (clock),
    .resetn (resetn),
    .pin    (ps2_clk_in),
    .level  (clk_level),
    .fall   (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clock  (clock),
    .resetn (resetn),
    .pin    (ps2_dat_in),
    .level  (dat_level),
    .fall   (dat_fall_unused)
  );

  // State and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      edge_cnt_q <= '0;
      frame_q    <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
    end else begin
      state_q    <= state_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      frame_q    <= frame_d;
      ps2_clk_oe <= clk_oe_d;
      ps2_dat_oe <= dat_oe_d;
      tx_ready   <= ready_d;
      tx_busy    <= busy_d;
      tx_done    <= done_d;
      tx_error   <= error_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    inh_cnt_d  = inh_cnt_q;
    to_cnt_d   = to_cnt_q;
    edge_cnt_d = edge_cnt_q;
    frame_d    = frame_q;
    clk_oe_d   = ps2_clk_oe;
    dat_oe_d   = ps2_dat_oe;
    done_d     = 1'b0;
    error_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_valid && tx_ready) begin
          frame_d   = {1'b1, odd_parity(tx_data), tx_data};
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = INHIBIT;
        end
      end

      INHIBIT: begin
        inh_cnt_d = inh_cnt_q + INH_W'(1);
        // Start bit goes low one cycle before the clock is released
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 2)) begin
          dat_oe_d = 1'b1;
        end
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          inh_cnt_d  = '0;
          to_cnt_d   = '0;
          edge_cnt_d = '0;
          clk_oe_d   = 1'b0;
          dat_oe_d   = 1'b1;
          state_d    = REQ;
        end
      end

      REQ, DATA: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (clk_fall) begin
          // Falls 1..10 present data[0..7], parity, then the stop release
          to_cnt_d   = '0;
          edge_cnt_d = edge_cnt_q + EDGE_W'(1);
          dat_oe_d   = ~frame_q[0];
          frame_d    = {1'b1, frame_q[FRAME_W-1:1]};
          state_d    = (edge_cnt_q == EDGE_W'(9)) ? ACK : DATA;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          error_d  = 1'b1;
          state_d  = IDLE;
        end
      end

      ACK: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (clk_fall) begin
          to_cnt_d   = '0;
          edge_cnt_d = edge_cnt_q + EDGE_W'(1);
          if (!dat_level) begin
            state_d = WAIT_IDLE;
          end else begin
            dat_oe_d = 1'b0;
            error_d  = 1'b1;
            state_d  = IDLE;
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          error_d  = 1'b1;
          state_d  = IDLE;
        end
      end

      WAIT_IDLE: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (clk_level && dat_level) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          error_d  = 1'b1;
          state_d  = IDLE;
        end
      end

      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH = 40;
  localparam int unsigned TO  = 150;
  localparam int unsigned H   = 10;

  logic       clock, resetn;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk, dev_dat;
  logic [10:0] dev_bits;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic       exp_par;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs[4];

  // Open-drain lines: either side can pull low
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Event monitor, sampled mid-cycle
  int   done_cnt = 0, err_cnt = 0, both_cnt = 0, overlap_cnt = 0;
  int   inh_starts = 0, clk_run = 0, last_inh = 0;
  logic prev_clk_oe = 1'b0;

  always @(negedge clock) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt <= err_cnt + 1;
    if (tx_done && tx_error) both_cnt <= both_cnt + 1;
    if (ps2_clk_oe && ps2_dat_oe) overlap_cnt <= overlap_cnt + 1;
    if (ps2_clk_oe && !prev_clk_oe) inh_starts <= inh_starts + 1;
    if (ps2_clk_oe) clk_run <= clk_run + 1;
    else if (clk_run != 0) begin
      last_inh <= clk_run;
      clk_run  <= 0;
    end
    prev_clk_oe <= ps2_clk_oe;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_wait(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Device: waits for request-to-send, clocks nfalls edges, samples data on
  // each rising edge (LSB first into dev_bits), drives ACK on fall 11
  task automatic device(input logic ack, input int nfalls, output bit ok);
    int w;
    ok = 1'b0;
    w  = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && w < 4 * INH + 20) begin
      @(negedge clock);
      w++;
    end
    if (w >= 4 * INH + 20) return;
    dev_bits = {ps2_dat_in, 10'h3FF};
    repeat (H) @(negedge clock);
    for (int k = 1; k <= nfalls && k <= 10; k++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge clock);
      dev_clk  = 1'b1;
      dev_bits = {ps2_dat_in, dev_bits[10:1]};
      repeat (H) @(negedge clock);
    end
    if (nfalls >= 11) begin
      dev_dat = ack ? 1'b0 : 1'b1;
      repeat (H / 2) @(negedge clock);
      dev_clk = 1'b0;
      repeat (H) @(negedge clock);
      dev_clk = 1'b1;
      repeat (2) @(negedge clock);
      dev_dat = 1'b1;
    end
    ok = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while (!(tx_ready && !tx_busy) && w < 200) begin
      @(negedge clock);
      w++;
    end
    if (w >= 200) fail_wait(name);
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic do_frame(input vec_t v, input string tag);
    int d0, e0, o0;
    bit ok;
    d0 = done_cnt;
    e0 = err_cnt;
    o0 = overlap_cnt;
    @(negedge clock);
    tx_data  = v.data;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    tx_data  = ~v.data;
    device(v.ack, 11, ok);
    if (!ok) fail_wait({tag, "_req"});
    wait_idle({tag, "_idle"});
    chk({tag, "_start"},   32'(dev_bits[0]),    32'(1'b0));
    chk({tag, "_data"},    32'(dev_bits[8:1]),  32'(v.data));
    chk({tag, "_parity"},  32'(dev_bits[9]),    32'(v.exp_par));
    chk({tag, "_stop"},    32'(dev_bits[10]),   32'(1'b1));
    chk({tag, "_inhibit"}, 32'(last_inh),       32'(INH));
    chk({tag, "_dat_first"}, 32'(overlap_cnt - o0), 32'(1));
    chk({tag, "_done"},    32'(done_cnt - d0),  32'(v.exp_done));
    chk({tag, "_error"},   32'(err_cnt - e0),   32'(v.exp_err));
    chk({tag, "_lines"},   32'({ps2_clk_oe, ps2_dat_oe}), 32'(2'b00));
    chk({tag, "_ready"},   32'(tx_ready),       32'(1'b1));
  endtask

  initial begin
    int  d0, e0, s0, w, cnt;
    bit  ok;

    vecs[0] = '{PS2_CMD_SET_LED, 1'b1, 1'b1, 1, 0};
    vecs[1] = '{PS2_CMD_ENABLE,  1'b1, 1'b0, 1, 0};
    vecs[2] = '{8'h00,           1'b1, 1'b1, 1, 0};
    vecs[3] = '{8'h5A,           1'b0, 1'b1, 0, 1};

    resetn   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    dev_bits = '0;
    repeat (3) @(negedge clock);
    chk("rst_ready",  32'(tx_ready),   32'(1'b1));
    chk("rst_busy",   32'(tx_busy),    32'(1'b0));
    chk("rst_done",   32'(tx_done),    32'(1'b0));
    chk("rst_error",  32'(tx_error),   32'(1'b0));
    chk("rst_clk_oe", 32'(ps2_clk_oe), 32'(1'b0));
    chk("rst_dat_oe", 32'(ps2_dat_oe), 32'(1'b0));
    resetn = 1'b1;
    repeat (3) @(negedge clock);

    for (int i = 0; i < 4; i++) begin
      do_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset after the fourth device clock fall
    @(negedge clock);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    device(1'b1, 4, ok);
    if (!ok) fail_wait("midrst_req");
    chk("midrst_pre_dat_oe", 32'(ps2_dat_oe), 32'(1'b1));
    chk("midrst_pre_busy",   32'(tx_busy),    32'(1'b1));
    #3 resetn = 1'b0;
    #1;
    chk("midrst_clk_oe", 32'(ps2_clk_oe), 32'(1'b0));
    chk("midrst_dat_oe", 32'(ps2_dat_oe), 32'(1'b0));
    chk("midrst_ready",  32'(tx_ready),   32'(1'b1));
    @(negedge clock);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    do_frame('{PS2_CMD_RESET, 1'b1, 1'b1, 1, 0}, "after_rst");

    // Device never clocks: timeout measured from request-to-send entry
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clock);
    tx_data  = 8'h12;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    w = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && w < 200) begin
      @(negedge clock);
      w++;
    end
    if (w >= 200) fail_wait("to_req");
    cnt = 0;
    while (!tx_error && cnt < int'(TO) + 50) begin
      @(negedge clock);
      cnt++;
    end
    chk("to_cycles", 32'(cnt), 32'(TO));
    chk("to_lines",  32'({ps2_clk_oe, ps2_dat_oe}), 32'(2'b00));
    @(negedge clock);
    @(negedge clock);
    chk("to_ready",  32'(tx_ready),       32'(1'b1));
    chk("to_error",  32'(err_cnt - e0),   32'(1));
    chk("to_done",   32'(done_cnt - d0),  32'(0));

    // tx_valid held through a whole frame: only one frame until idle
    d0 = done_cnt;
    s0 = inh_starts;
    @(negedge clock);
    tx_data  = PS2_CMD_ENABLE;
    tx_valid = 1'b1;
    device(1'b1, 11, ok);
    if (!ok) fail_wait("hold_req1");
    w = 0;
    while (done_cnt == d0 && w < 100) begin
      @(negedge clock);
      w++;
    end
    if (w >= 100) fail_wait("hold_done1");
    chk("hold_data1",   32'(dev_bits[8:1]), 32'(PS2_CMD_ENABLE));
    chk("hold_parity1", 32'(dev_bits[9]),   32'(1'b0));
    chk("hold_done1",   32'(done_cnt - d0), 32'(1));
    w = 0;
    while (!tx_busy && w < 10) begin
      @(negedge clock);
      w++;
    end
    if (w >= 10) fail_wait("hold_accept2");
    tx_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("hold_starts2", 32'(inh_starts - s0), 32'(2));
    device(1'b1, 11, ok);
    if (!ok) fail_wait("hold_req2");
    wait_idle("hold_idle2");
    chk("hold_done2",   32'(done_cnt - d0),   32'(2));
    chk("hold_starts",  32'(inh_starts - s0), 32'(2));

    chk("never_done_and_error", 32'(both_cnt), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
